shift_deserializer: RTL and testbench

Parametrised serial-to-parallel stream deserializer. Collects single-bit valid/ready beats into WIDTH-bit words and presents each word on a valid/ready output stream. Double-buffered: a shift stage plus an output holding register, so input flow continues while a finished word waits for the sink. Supports MSB-first or LSB-first packing, and either one-shot capture or continuous streaming. Sits between bit-serial front-ends (sensor/SPI-style samplers) and word-wide Core_clk logic.

---
 rtl/shift_deserializer_pkg.sv | 32 +++
 rtl/shift_deserializer_stream_hold_reg.sv | 54 +++++
 rtl/shift_deserializer.sv | 122 ++++++++++++
 tb/tb_shift_deserializer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_deserializer_pkg
//  Description : Shared constants and helpers for the serial-to-parallel
//                deserializer and its holding register.
//                - Packing-order constants (PACK_MSB_FIRST / PACK_LSB_FIRST)
//                - Capture-mode constants (MODE_STREAM / MODE_ONE_SHOT)
//                - clog2() for sizing the bit counter
//  Revision    : 1.0  initial release
// ============================================================================
package shift_deserializer_pkg;

    localparam int PACK_MSB_FIRST = 0;  // first bit lands in payload[WIDTH-1]
    localparam int PACK_LSB_FIRST = 1;  // first bit lands in payload[0]

    localparam int MODE_STREAM    = 0;  // continuous word stream
    localparam int MODE_ONE_SHOT  = 1;  // one word, then stall until cleared

    // Smallest r such that 2**r >= value (value >= 2 in this codebase).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : shift_deserializer_pkg
`default_nettype wire

// File: rtl/shift_deserializer_stream_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_hold_reg
//  Description : WIDTH-wide valid/ready holding register. A load captures a
//                word and raises valid; a pop (sink ready) drops valid unless
//                a load arrives in the same cycle, in which case the new word
//                replaces the old one with no bubble. Clear wins over both.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                i_clear    - synchronous clear of valid and data
//                i_load     - capture i_loadData this cycle
//                i_loadData - word to capture
//                i_pop      - sink ready; consumes the held word if valid
//                o_valid    - a word is held
//                o_data     - held word
//  Revision    : 1.0  initial release
// ============================================================================
module stream_hold_reg #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadData,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            // Load covers the simultaneous pop+load case: valid stays high.
            r_valid <= 1'b1;
            r_data  <= i_loadData;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : stream_hold_reg
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_deserializer
//  Description : Serial-to-parallel stream deserializer. Single-bit
//                valid/ready beats are packed into WIDTH-bit words in a shift
//                stage; each finished word moves to an output holding
//                register so the shift stage keeps accepting bits while the
//                sink is stalled. MSB- or LSB-first packing; one-shot or
//                continuous capture.
//  Ports       : Core_clk           - clock, rising edge
//                Core_reset         - asynchronous active-high reset
//                io_dataIn_valid    - serial bit valid
//                io_dataIn_ready    - bit accepted this cycle
//                io_dataIn_payload  - serial bit
//                io_dataOut_valid   - assembled word available
//                io_dataOut_ready   - sink accepts word
//                io_dataOut_payload - assembled word
//                io_resetBuffer     - synchronous clear of all datapath state
//                io_bitCount        - bits held in the shift stage
//  Revision    : 1.0  initial release
// ============================================================================
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int WIDTH     = 17,
    parameter int LSB_FIRST = PACK_MSB_FIRST,
    parameter int ONE_SHOT  = MODE_ONE_SHOT
) (
    input  logic                      Core_clk,
    input  logic                      Core_reset,
    input  logic                      io_dataIn_valid,
    output logic                      io_dataIn_ready,
    input  logic                      io_dataIn_payload,
    output logic                      io_dataOut_valid,
    input  logic                      io_dataOut_ready,
    output logic [WIDTH-1:0]          io_dataOut_payload,
    input  logic                      io_resetBuffer,
    output logic [clog2(WIDTH)-1:0]   io_bitCount
);

    localparam int              c_CW   = clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_shiftReg;
    logic [c_CW-1:0]  r_bitCnt;
    logic [WIDTH-1:0] w_packed;
    logic             w_done;
    logic             w_outValid;
    logic             w_lastBit;
    logic             w_inReady;
    logic             w_inFire;
    logic             w_load;

    assign w_lastBit = (r_bitCnt == c_LAST);

    // Only the word-completing bit needs room in the holding register; a
    // pop in the same cycle frees that room, hence the combinational path
    // from io_dataOut_ready.
    assign w_inReady = !w_done && (!w_lastBit || !w_outValid || io_dataOut_ready);
    assign w_inFire  = io_dataIn_valid && w_inReady;
    assign w_load    = w_inFire && w_lastBit;

    // Shifted value including the incoming bit; this is also the finished
    // word when the current bit completes it.
    generate
        if (LSB_FIRST == PACK_LSB_FIRST) begin : g_packLsb
            assign w_packed = WIDTH'({io_dataIn_payload, r_shiftReg} >> 1);
        end else begin : g_packMsb
            assign w_packed = WIDTH'({r_shiftReg, io_dataIn_payload});
        end
    endgenerate

    always_ff @(posedge Core_clk or posedge Core_reset) begin
        if (Core_reset) begin
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
        end else if (io_resetBuffer) begin
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
        end else if (w_inFire) begin
            r_shiftReg <= w_packed;
            r_bitCnt   <= w_lastBit ? '0 : r_bitCnt + c_CW'(1);
        end
    end

    generate
        if (ONE_SHOT == MODE_ONE_SHOT) begin : g_oneShot
            logic r_done;
            always_ff @(posedge Core_clk or posedge Core_reset) begin
                if (Core_reset) begin
                    r_done <= 1'b0;
                end else if (io_resetBuffer) begin
                    r_done <= 1'b0;
                end else if (w_load) begin
                    r_done <= 1'b1;
                end
            end
            assign w_done = r_done;
        end else begin : g_stream
            assign w_done = 1'b0;
        end
    endgenerate

    stream_hold_reg #(
        .WIDTH (WIDTH)
    ) u_holdReg (
        .clk        (Core_clk),
        .rst        (Core_reset),
        .i_clear    (io_resetBuffer),
        .i_load     (w_load),
        .i_loadData (w_packed),
        .i_pop      (io_dataOut_ready),
        .o_valid    (w_outValid),
        .o_data     (io_dataOut_payload)
    );

    assign io_dataIn_ready  = w_inReady;
    assign io_dataOut_valid = w_outValid;
    assign io_bitCount      = r_bitCnt;

endmodule : shift_deserializer
`default_nettype wire

// File: tb/tb_shift_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_deserializer
//  Description : Directed self-checking bench for shift_deserializer.
//                uA: WIDTH=17, MSB-first, one-shot
//                uB: WIDTH=8,  LSB-first, streaming
//                uC: WIDTH=8,  MSB-first, streaming
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_deserializer;

    logic Core_clk   = 1'b0;
    logic Core_reset = 1'b1;
    always #5 Core_clk = ~Core_clk;

    // uA
    logic        aInValid, aInBit, aInReady, aOutValid, aOutReady, aRstBuf;
    logic [16:0] aOut;
    logic [4:0]  aCnt;
    // uB
    logic        bInValid, bInBit, bInReady, bOutValid, bOutReady, bRstBuf;
    logic [7:0]  bOut;
    logic [2:0]  bCnt;
    // uC
    logic        cInValid, cInBit, cInReady, cOutValid, cOutReady, cRstBuf;
    logic [7:0]  cOut;
    logic [2:0]  cCnt;

    shift_deserializer #(.WIDTH(17), .LSB_FIRST(0), .ONE_SHOT(1)) uA (
        .Core_clk(Core_clk), .Core_reset(Core_reset),
        .io_dataIn_valid(aInValid), .io_dataIn_ready(aInReady),
        .io_dataIn_payload(aInBit), .io_dataOut_valid(aOutValid),
        .io_dataOut_ready(aOutReady), .io_dataOut_payload(aOut),
        .io_resetBuffer(aRstBuf), .io_bitCount(aCnt));

    shift_deserializer #(.WIDTH(8), .LSB_FIRST(1), .ONE_SHOT(0)) uB (
        .Core_clk(Core_clk), .Core_reset(Core_reset),
        .io_dataIn_valid(bInValid), .io_dataIn_ready(bInReady),
        .io_dataIn_payload(bInBit), .io_dataOut_valid(bOutValid),
        .io_dataOut_ready(bOutReady), .io_dataOut_payload(bOut),
        .io_resetBuffer(bRstBuf), .io_bitCount(bCnt));

    shift_deserializer #(.WIDTH(8), .LSB_FIRST(0), .ONE_SHOT(0)) uC (
        .Core_clk(Core_clk), .Core_reset(Core_reset),
        .io_dataIn_valid(cInValid), .io_dataIn_ready(cInReady),
        .io_dataIn_payload(cInBit), .io_dataOut_valid(cOutValid),
        .io_dataOut_ready(cOutReady), .io_dataOut_payload(cOut),
        .io_resetBuffer(cRstBuf), .io_bitCount(cCnt));

    int nTests = 0;
    int nFail  = 0;

    // Output-handshake monitors
    int         cycle  = 0;
    int         aFires = 0;
    logic [7:0] cFireData[$];
    int         cFireCyc[$];

    always @(posedge Core_clk) begin
        cycle <= cycle + 1;
        if (aOutValid && aOutReady) aFires <= aFires + 1;
        if (cOutValid && cOutReady) begin
            cFireData.push_back(cOut);
            cFireCyc.push_back(cycle);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge Core_clk);
        #2;
    endtask

    task automatic sendC(input logic b);
        cInValid = 1'b1;
        cInBit   = b;
        tick();
    endtask

    initial begin
        logic [7:0]  w;
        logic [7:0]  bBits;
        logic [63:0] stream;
        int          errs;
        int          n;

        {aInValid, aInBit, aOutReady, aRstBuf} = '0;
        {bInValid, bInBit, bOutReady, bRstBuf} = '0;
        {cInValid, cInBit, cOutReady, cRstBuf} = '0;
        #12 Core_reset = 1'b0;
        tick();

        // ---------------- reset state ----------------
        check("rst_aReady", 64'(aInReady), 64'(1));
        check("rst_aValid", 64'(aOutValid), 64'(0));
        check("rst_aPayload", 64'(aOut), 64'(0));
        check("rst_aCnt", 64'(aCnt), 64'(0));
        check("rst_cReady", 64'(cInReady), 64'(1));
        check("rst_cValid", 64'(cOutValid), 64'(0));

        // ---------------- A: one-shot 17-bit MSB-first ----------------
        aOutReady = 1'b1;
        for (int i = 0; i < 17; i++) begin
            aInValid = 1'b1;
            aInBit   = (i % 2 == 0);
            if (i == 16) check("A_cnt16", 64'(aCnt), 64'(16));
            tick();
        end
        check("A_valid", 64'(aOutValid), 64'(1));
        check("A_payload", 64'(aOut), 64'h15555);
        check("A_readyDone", 64'(aInReady), 64'(0));
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (aInReady !== 1'b0 || aOutValid !== 1'b0) errs++;
        end
        check("A_stall20", 64'(errs), 64'(0));
        check("A_fires", 64'(aFires), 64'(1));
        aRstBuf = 1'b1;
        tick();
        aRstBuf  = 1'b0;
        aInValid = 1'b0;
        #1;
        check("A_readyRestored", 64'(aInReady), 64'(1));
        check("A_cntCleared", 64'(aCnt), 64'(0));

        // ---------------- B: LSB-first 8-bit ----------------
        bOutReady = 1'b1;
        bBits     = 8'b1000_0011;  // index = send order
        for (int i = 0; i < 8; i++) begin
            bInValid = 1'b1;
            bInBit   = bBits[i];
            tick();
        end
        bInValid = 1'b0;
        check("B_valid", 64'(bOutValid), 64'(1));
        check("B_payload", 64'(bOut), 64'h83);

        // ---------------- C: backpressure, same-cycle pop+load ----------------
        cOutReady = 1'b0;
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) sendC(w[i]);
        check("C_validA5", 64'(cOutValid), 64'(1));
        check("C_payloadA5", 64'(cOut), 64'hA5);
        check("C_cnt0", 64'(cCnt), 64'(0));
        w = 8'h3C;
        errs = 0;
        for (int i = 7; i >= 1; i--) begin
            cInValid = 1'b1;
            cInBit   = w[i];
            if (cInReady !== 1'b1) errs++;
            tick();
        end
        check("C_accept7", 64'(errs), 64'(0));
        check("C_cnt7", 64'(cCnt), 64'(7));
        check("C_readyLow", 64'(cInReady), 64'(0));
        check("C_holdA5", 64'(cOut), 64'hA5);
        n = cFireData.size();
        cInBit    = w[0];
        cOutReady = 1'b1;
        #1;
        check("C_readyComb", 64'(cInReady), 64'(1));
        tick();
        check("C_valid3C", 64'(cOutValid), 64'(1));
        check("C_payload3C", 64'(cOut), 64'h3C);
        check("C_popA5", 64'(cFireData.size()), 64'(n + 1));
        cInValid = 1'b0;
        tick();
        check("C_drained", 64'(cOutValid), 64'(0));

        // ---------------- D: 64 back-to-back bits ----------------
        stream = {$urandom, $urandom};
        cFireData.delete();
        cFireCyc.delete();
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            cInValid = 1'b1;
            cInBit   = stream[63 - i];
            if (cInReady !== 1'b1) errs++;
            tick();
        end
        cInValid = 1'b0;
        tick();
        check("D_readyDrop", 64'(errs), 64'(0));
        check("D_words", 64'(cFireData.size()), 64'(8));
        for (int j = 0; j < 8 && j < cFireData.size(); j++) begin
            check($sformatf("D_word%0d", j), 64'(cFireData[j]), 64'(stream[63 - 8 * j -: 8]));
            if (j > 0)
                check($sformatf("D_gap%0d", j), 64'(cFireCyc[j] - cFireCyc[j - 1]), 64'(8));
        end

        // ---------------- E: asynchronous reset mid-word ----------------
        cOutReady = 1'b0;
        for (int i = 0; i < 8; i++) sendC(1'b1);
        for (int i = 0; i < 5; i++) sendC(1'b1);
        cInValid = 1'b0;
        check("E_cnt5", 64'(cCnt), 64'(5));
        check("E_validBefore", 64'(cOutValid), 64'(1));
        #1 Core_reset = 1'b1;
        #1;
        check("E_rstValid", 64'(cOutValid), 64'(0));
        check("E_rstPayload", 64'(cOut), 64'(0));
        check("E_rstCnt", 64'(cCnt), 64'(0));
        check("E_rstReady", 64'(cInReady), 64'(1));
        #1 Core_reset = 1'b0;
        w = 8'h5A;
        for (int i = 7; i >= 0; i--) sendC(w[i]);
        cInValid = 1'b0;
        check("E_cleanValid", 64'(cOutValid), 64'(1));
        check("E_cleanWord", 64'(cOut), 64'h5A);

        // ---------------- F: resetBuffer with completing bit + out_fire ----------------
        w = 8'hC3;
        for (int i = 7; i >= 1; i--) sendC(w[i]);
        check("F_cnt7", 64'(cCnt), 64'(7));
        n = cFireData.size();
        cInValid  = 1'b1;
        cInBit    = w[0];
        cOutReady = 1'b1;
        cRstBuf   = 1'b1;
        tick();
        {cInValid, cOutReady, cRstBuf} = '0;
        check("F_valid", 64'(cOutValid), 64'(0));
        check("F_cnt", 64'(cCnt), 64'(0));
        check("F_payload", 64'(cOut), 64'(0));
        check("F_delivered", 64'(cFireData.size()), 64'(n + 1));
        if (cFireData.size() > 0)
            check("F_oldWord", 64'(cFireData[cFireData.size() - 1]), 64'h5A);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_shift_deserializer
`default_nettype wire
